// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one SRAM-like bus between instruction fetch (read only)
// and data access (read/write), one outstanding transaction at a time.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  logic [2:0]          state;
  logic [2:0]          nextState;
  logic                owner;
  logic [STREAK_W-1:0] streak;
  logic                anyReq;
  logic                grantMem;

  assign anyReq = if_req | mem_req;
  // MEM has priority unless IF has been starved for STARVE_LIMIT grants in a row.
  assign grantMem = mem_req && !(if_req && (streak == STREAK_MAX));

  // Next-state logic; flush either aborts an unissued request or drains an accepted one.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ADDR;
      ADDR: begin
        if (bus_addr_ok)  nextState = flush ? DRAIN : DATA;
        else if (flush)   nextState = IDLE;
      end
      DATA: begin
        if (bus_data_ok)  nextState = flush ? IDLE : DONE;
        else if (flush)   nextState = DRAIN;
      end
      DONE:    nextState = IDLE;
      DRAIN:   if (bus_data_ok) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, arbitration bookkeeping, latched bus command and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      streak    <= '0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && anyReq) begin
        if (grantMem) begin
          owner     <= OWN_MEM;
          bus_wr    <= mem_wr;
          bus_size  <= mem_size;
          bus_addr  <= mem_addr;
          bus_wdata <= mem_wdata;
          if (if_req) streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 1'b1;
          else        streak <= '0;
        end else begin
          owner     <= OWN_IF;
          bus_wr    <= 1'b0;
          bus_size  <= 2'd2;
          bus_addr  <= if_addr;
          bus_wdata <= '0;
          streak    <= '0;
        end
      end
      // A flush arriving with the data turns this into a drain: the data is dropped.
      if (state == DATA && bus_data_ok && !flush && !bus_wr) begin
        if (owner == OWN_MEM) mem_rdata <= bus_rdata;
        else                  if_rdata  <= bus_rdata;
      end
    end
  end

  // Request is held for the whole ADDR state, so the command stays stable until accepted.
  always_comb begin
    bus_req = (state == ADDR);
  end

  // Stalls depend only on registered state plus the requesters' own req lines.
  always_comb begin
    if_stall  = !rst && ((if_req && !(state == DONE && owner == OWN_IF)) || state == DRAIN);
    mem_stall = !rst && ((mem_req && !(state == DONE && owner == OWN_MEM)) || state == DRAIN);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] expIf;
  logic [31:0] expMem;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_stall(if_stall),
    .mem_req(mem_req),
    .mem_wr(mem_wr),
    .mem_size(mem_size),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .bus_req(bus_req),
    .bus_wr(bus_wr),
    .bus_size(bus_size),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs for the new cycle are set afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transaction starting in an IDLE cycle whose requests are already driven.
  // Checks who got the bus from the issued address; returns in the following IDLE cycle.
  task automatic xact(input string tag, input logic [31:0] expAddr, input logic expMemOwner,
                      input logic [31:0] rdata);
    tick();                                   // ADDR
    bus_addr_ok = 1'b1;
    #1;
    chk({tag, "_addr"}, bus_addr, expAddr);
    tick();                                   // DATA
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rdata;
    tick();                                   // DONE
    bus_data_ok = 1'b0;
    #1;
    if (expMemOwner) begin
      expMem = rdata;
      chk({tag, "_memstall"}, {31'd0, mem_stall}, 32'd0);
      chk({tag, "_ifstall"},  {31'd0, if_stall},  32'd1);
      chk({tag, "_mrdata"},   mem_rdata, expMem);
    end else begin
      expIf = rdata;
      chk({tag, "_ifstall"}, {31'd0, if_stall}, 32'd0);
      chk({tag, "_irdata"},  if_rdata, expIf);
    end
    tick();                                   // IDLE
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_req = 1'b1; if_addr = 32'h0;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd0; mem_addr = 32'h0; mem_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    expIf = 32'h0; expMem = 32'h0;

    // Reset: stalls forced low even with requests pending.
    #12;
    chk("rst_busreq",   {31'd0, bus_req},   32'd0);
    chk("rst_ifstall",  {31'd0, if_stall},  32'd0);
    chk("rst_memstall", {31'd0, mem_stall}, 32'd0);
    chk("rst_ifrdata",  if_rdata, 32'd0);
    chk("rst_busaddr",  bus_addr, 32'd0);
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // IF-only read, zero-wait slave.
    tick();
    if_req = 1'b1; if_addr = 32'hBFC00000;    // c0
    #1;
    chk("if_c0_stall", {31'd0, if_stall}, 32'd1);
    chk("if_c0_busreq", {31'd0, bus_req}, 32'd0);
    tick();                                   // c1
    bus_addr_ok = 1'b1;
    #1;
    chk("if_c1_busreq", {31'd0, bus_req}, 32'd1);
    chk("if_c1_addr", bus_addr, 32'hBFC00000);
    chk("if_c1_wr",   {31'd0, bus_wr}, 32'd0);
    chk("if_c1_size", {30'd0, bus_size}, 32'd2);
    chk("if_c1_stall", {31'd0, if_stall}, 32'd1);
    tick();                                   // c2
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h24080001;
    #1;
    chk("if_c2_busreq", {31'd0, bus_req}, 32'd0);
    chk("if_c2_stall", {31'd0, if_stall}, 32'd1);
    tick();                                   // c3
    bus_data_ok = 1'b0;
    #1;
    expIf = 32'h24080001;
    chk("if_c3_stall", {31'd0, if_stall}, 32'd0);
    chk("if_c3_rdata", if_rdata, expIf);
    tick();                                   // IDLE
    if_req = 1'b0;

    // Simultaneous IF read and MEM write: MEM first, IF stays stalled.
    tick();
    if_req = 1'b1; if_addr = 32'h00000100;
    mem_req = 1'b1; mem_wr = 1'b1; mem_size = 2'd2;
    mem_addr = 32'h80001000; mem_wdata = 32'hDEADBEEF;
    #1;
    chk("both_c0_ifstall", {31'd0, if_stall}, 32'd1);
    chk("both_c0_memstall", {31'd0, mem_stall}, 32'd1);
    tick();
    bus_addr_ok = 1'b1;
    #1;
    chk("both_c1_wr",    {31'd0, bus_wr}, 32'd1);
    chk("both_c1_addr",  bus_addr, 32'h80001000);
    chk("both_c1_wdata", bus_wdata, 32'hDEADBEEF);
    chk("both_c1_size",  {30'd0, bus_size}, 32'd2);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
    #1;
    chk("both_c2_ifstall", {31'd0, if_stall}, 32'd1);
    tick();
    bus_data_ok = 1'b0;
    #1;
    chk("both_c3_memstall", {31'd0, mem_stall}, 32'd0);
    chk("both_c3_ifstall",  {31'd0, if_stall},  32'd1);
    chk("both_c3_wr_norcap", mem_rdata, expMem);
    tick();                                   // IDLE
    mem_req = 1'b0; mem_wr = 1'b0;
    #1;
    chk("both_c4_ifstall", {31'd0, if_stall}, 32'd1);
    xact("both_if", 32'h00000100, 1'b0, 32'hCAFEF00D);
    if_req = 1'b0;

    // Starvation: four MEM grants, then IF, then MEM again (streak cleared).
    tick();
    if_req = 1'b1; if_addr = 32'h00003000;
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd2; mem_addr = 32'h00002000;
    xact("stv0", 32'h00002000, 1'b1, 32'hA0000000);
    xact("stv1", 32'h00002000, 1'b1, 32'hA0000001);
    xact("stv2", 32'h00002000, 1'b1, 32'hA0000002);
    xact("stv3", 32'h00002000, 1'b1, 32'hA0000003);
    xact("stv4", 32'h00003000, 1'b0, 32'hA0000004);
    xact("stv5", 32'h00002000, 1'b1, 32'hA0000005);
    if_req = 1'b0; mem_req = 1'b0;

    // Slave delays addr_ok by 3 cycles: command stable for 4 cycles.
    tick();
    mem_req = 1'b1; mem_wr = 1'b0; mem_size = 2'd1; mem_addr = 32'h00004000;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus_addr_ok = (k == 3);
      #1;
      chk("dly_busreq", {31'd0, bus_req}, 32'd1);
      chk("dly_addr", bus_addr, 32'h00004000);
      chk("dly_size", {30'd0, bus_size}, 32'd1);
    end
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h00005A5A;
    #1;
    chk("dly_data_stall", {31'd0, mem_stall}, 32'd1);
    tick();
    bus_data_ok = 1'b0;
    #1;
    expMem = 32'h00005A5A;
    chk("dly_done_stall", {31'd0, mem_stall}, 32'd0);
    chk("dly_rdata", mem_rdata, expMem);
    tick();
    mem_req = 1'b0;

    // Flush in ADDR before addr_ok: abort, nothing issued.
    tick();
    mem_req = 1'b1; mem_addr = 32'h00006000;
    tick();                                   // ADDR
    flush = 1'b1; mem_req = 1'b0;
    #1;
    chk("fa_busreq_addr", {31'd0, bus_req}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fa_busreq_idle", {31'd0, bus_req}, 32'd0);
    chk("fa_memstall",    {31'd0, mem_stall}, 32'd0);
    tick();
    #1;
    chk("fa_stay_idle", {31'd0, bus_req}, 32'd0);

    // Flush in DATA, data_ok two cycles later: drain and discard.
    if_req = 1'b1; if_addr = 32'h00007000;
    tick();                                   // ADDR
    bus_addr_ok = 1'b1;
    tick();                                   // DATA
    bus_addr_ok = 1'b0; flush = 1'b1; if_req = 1'b0;
    tick();                                   // DRAIN
    flush = 1'b0;
    #1;
    chk("fd_ifstall",  {31'd0, if_stall},  32'd1);
    chk("fd_memstall", {31'd0, mem_stall}, 32'd1);
    chk("fd_busreq",   {31'd0, bus_req},   32'd0);
    tick();                                   // DRAIN, data arrives
    bus_data_ok = 1'b1; bus_rdata = 32'hBAD0BAD0;
    #1;
    chk("fd_ifstall2", {31'd0, if_stall}, 32'd1);
    tick();                                   // IDLE
    bus_data_ok = 1'b0;
    #1;
    chk("fd_idle_ifstall",  {31'd0, if_stall},  32'd0);
    chk("fd_idle_memstall", {31'd0, mem_stall}, 32'd0);
    chk("fd_ifrdata",  if_rdata,  expIf);
    chk("fd_memrdata", mem_rdata, expMem);

    // Asynchronous reset in DATA.
    mem_req = 1'b1; mem_addr = 32'h00008000;
    tick();                                   // ADDR
    bus_addr_ok = 1'b1;
    tick();                                   // DATA
    bus_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busreq",   {31'd0, bus_req},   32'd0);
    chk("ar_memstall", {31'd0, mem_stall}, 32'd0);
    chk("ar_busaddr",  bus_addr, 32'd0);
    chk("ar_memrdata", mem_rdata, 32'd0);
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("ar_idle_busreq", {31'd0, bus_req}, 32'd0);
    mem_req = 1'b1; mem_addr = 32'h00009000;
    tick();
    #1;
    chk("ar_regrant_busreq", {31'd0, bus_req}, 32'd1);
    chk("ar_regrant_addr",   bus_addr, 32'h00009000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
